// File: rtl/mgmt_gpio_flash_blinker.sv
// mgmt_gpio_flash_blinker: boot-time management GPIO sequencer.
// Fetches a 4-byte blink descriptor {N, H[23:0]} from SPI flash (mode 0, MSB first).
// It then toggles gpio N times, with H clocks high and H clocks low per pulse.
// Build option: define FLASH_FAST_READ_EN to use the 0x0B fast-read command.
// In that build, 8 dummy SPI clocks are inserted between the address and the data.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | one cycle after reset release, loads command word
// CMD      | shifting out command byte + 24-bit address on io0
// DUMMY    | fast-read dummy clocks (FLASH_FAST_READ_EN builds only)
// DATA     | shifting in 32 descriptor bits from io1
// BLINK_HI | gpio high for H clocks
// BLINK_LO | gpio low for H clocks, then bump blink count
// DONE     | sequence finished, held until reset
module mgmt_gpio_flash_blinker #(
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter logic [7:0]  MAX_COUNT  = 8'hFF
) (
  input  logic       clock,
  input  logic       resetb,
  output logic       flash_csb,
  output logic       flash_clk,
  output logic       flash_io0,
  input  logic       flash_io1,
  output logic       gpio,
  input  logic [7:0] checkbits_lo,
  output logic [7:0] checkbits_hi,
  output logic       done
);

`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
  localparam logic [7:0] CMD_BYTE = 8'h03;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_DUMMY, S_DATA, S_BLINK_HI, S_BLINK_LO, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        csb_q;
  logic        clk_q;
  logic [31:0] shift_q;
  logic [31:0] data_q;
  logic [4:0]  bit_q;
  logic [7:0]  n_q;
  logic [23:0] half_q;
  logic [23:0] tmr_q;
  logic [7:0]  cnt_q;
  logic [7:0]  chk_lo_unused_q;

  logic [23:0] desc_h;
  logic [7:0]  cnt_inc;
  logic        tmr_done;
  logic        bit_end_32;
  logic        bit_end_8;

  // A zero half-period would never expire, so it is promoted to one clock
  assign desc_h     = (data_q[23:0] == 24'd0) ? 24'd1 : data_q[23:0];
  assign cnt_inc    = (cnt_q == MAX_COUNT) ? cnt_q : cnt_q + 8'd1;
  assign tmr_done   = (tmr_q == 24'd0);
  // A SPI bit ends on the edge that drives flash_clk back low
  assign bit_end_32 = clk_q && (bit_q == 5'd31);
  assign bit_end_8  = clk_q && (bit_q == 5'd7);

  // State register
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: state_d = S_CMD;
      S_CMD: begin
        if (bit_end_32) begin
`ifdef FLASH_FAST_READ_EN
          state_d = S_DUMMY;
`else
          state_d = S_DATA;
`endif
        end
      end
      S_DUMMY: if (bit_end_8) state_d = S_DATA;
      S_DATA: begin
        if (bit_end_32) state_d = (data_q[31:24] == 8'd0) ? S_DONE : S_BLINK_HI;
      end
      S_BLINK_HI: if (tmr_done) state_d = S_BLINK_LO;
      S_BLINK_LO: begin
        if (tmr_done) state_d = (cnt_inc == n_q) ? S_DONE : S_BLINK_HI;
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and SPI registers
  always_comb begin
    gpio         = (state_q == S_BLINK_HI);
    done         = (state_q == S_DONE);
    flash_io0    = (state_q == S_CMD) ? shift_q[31] : 1'b0;
    flash_csb    = csb_q;
    flash_clk    = clk_q;
    checkbits_hi = cnt_q;
  end

  // SPI shifter, descriptor capture, half-period timer and blink counter
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      csb_q           <= 1'b1;
      clk_q           <= 1'b0;
      shift_q         <= 32'd0;
      data_q          <= 32'd0;
      bit_q           <= 5'd0;
      n_q             <= 8'd0;
      half_q          <= 24'd0;
      tmr_q           <= 24'd0;
      cnt_q           <= 8'd0;
      chk_lo_unused_q <= 8'd0;
    end else begin
      chk_lo_unused_q <= checkbits_lo;
      unique case (state_q)
        S_IDLE: begin
          csb_q   <= 1'b0;
          clk_q   <= 1'b0;
          shift_q <= {CMD_BYTE, FLASH_BASE};
          bit_q   <= 5'd0;
          cnt_q   <= 8'd0;
        end
        S_CMD, S_DUMMY, S_DATA: begin
          clk_q <= ~clk_q;
          if ((state_q == S_DATA) && !clk_q) data_q <= {data_q[30:0], flash_io1};
          if (clk_q) begin
            shift_q <= {shift_q[30:0], 1'b0};
            bit_q   <= (state_d != state_q) ? 5'd0 : bit_q + 5'd1;
          end
          if ((state_q == S_DATA) && (state_d != S_DATA)) begin
            csb_q  <= 1'b1;
            n_q    <= data_q[31:24];
            half_q <= desc_h;
            tmr_q  <= desc_h - 24'd1;
          end
        end
        S_BLINK_HI, S_BLINK_LO: begin
          tmr_q <= tmr_done ? half_q - 24'd1 : tmr_q - 24'd1;
          if ((state_q == S_BLINK_LO) && tmr_done) cnt_q <= cnt_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mgmt_gpio_flash_blinker.sv
// Directed bench for mgmt_gpio_flash_blinker with a behavioural SPI flash.
module tb_mgmt_gpio_flash_blinker;

`ifdef FLASH_FAST_READ_EN
  localparam int          EXTRA    = 16;
  localparam int          BITS_EXP = 72;
  localparam int          OFS      = 40;
  localparam logic [31:0] CMD_EXP  = 32'h0B000000;
`else
  localparam int          EXTRA    = 0;
  localparam int          BITS_EXP = 64;
  localparam int          OFS      = 32;
  localparam logic [31:0] CMD_EXP  = 32'h03000000;
`endif
  localparam int T0 = 129 + EXTRA;  // first negedge with blink state active

  logic       clock = 1'b0;
  logic       resetb = 1'b1;
  logic       flash_csb, flash_clk, flash_io0, flash_io1, gpio, done;
  logic [7:0] checkbits_lo = 8'h00;
  logic [7:0] checkbits_hi;

  logic [31:0] resp = 32'd0;
  int          spi_cnt = 0;
  logic [71:0] mosi = '0;

  int   nasrt = 0, nfail = 0, cyc = 0;
  logic mon_clr = 1'b1;
  int   pulses = 0, hi_run = 0, lo_run = 0;
  int   hi_min = 0, hi_max = 0, lo_min = 0, lo_max = 0;

  always #5 clock = ~clock;

  mgmt_gpio_flash_blinker dut (
    .clock(clock), .resetb(resetb),
    .flash_csb(flash_csb), .flash_clk(flash_clk),
    .flash_io0(flash_io0), .flash_io1(flash_io1),
    .gpio(gpio), .checkbits_lo(checkbits_lo),
    .checkbits_hi(checkbits_hi), .done(done)
  );

  // Flash model: counts SPI rising edges per transaction, records MOSI
  always @(posedge flash_clk or negedge flash_csb) begin
    if (!flash_clk) begin
      spi_cnt <= 0;
      mosi    <= '0;
    end else begin
      spi_cnt <= spi_cnt + 1;
      mosi    <= {mosi[70:0], flash_io0};
    end
  end

  always_comb begin
    flash_io1 = 1'b0;
    if (spi_cnt >= OFS && spi_cnt < OFS + 32) flash_io1 = resp[5'(31 - (spi_cnt - OFS))];
  end

  // Pulse monitor: pulse count and min/max high and between-pulse low widths
  always @(negedge clock) begin
    if (mon_clr) begin
      pulses <= 0; hi_run <= 0; lo_run <= 0;
      hi_min <= 1 << 30; hi_max <= 0; lo_min <= 1 << 30; lo_max <= 0;
    end else if (gpio === 1'b1) begin
      hi_run <= hi_run + 1;
      lo_run <= 0;
      if (hi_run == 0) begin
        pulses <= pulses + 1;
        if (pulses != 0) begin
          if (lo_run < lo_min) lo_min <= lo_run;
          if (lo_run > lo_max) lo_max <= lo_run;
        end
      end
    end else begin
      if (hi_run != 0) begin
        if (hi_run < hi_min) hi_min <= hi_run;
        if (hi_run > hi_max) hi_max <= hi_run;
      end
      hi_run <= 0;
      lo_run <= lo_run + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
    cyc += n;
  endtask

  task automatic start(input logic [31:0] r, input int nrst);
    resetb  = 1'b0;
    mon_clr = 1'b1;
    resp    = r;
    repeat (nrst) @(negedge clock);
    resetb  = 1'b1;
    mon_clr = 1'b0;
    cyc     = 0;
  endtask

  task automatic wait_done(input int limit);
    while (done !== 1'b1 && cyc < limit) step(1);
  endtask

  initial begin
    #1 resetb = 1'b0;
    #1;
    check("rst_csb", 32'(flash_csb), 32'd1);
    check("rst_clk", 32'(flash_clk), 32'd0);
    check("rst_io0", 32'(flash_io0), 32'd0);
    check("rst_gpio", 32'(gpio), 32'd0);
    check("rst_hi", 32'(checkbits_hi), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // Scenario 1: N=10, H=4
    checkbits_lo = 8'hA5;
    start(32'h0A000004, 3);
    step(1);
    check("s1_csb_low", 32'(flash_csb), 32'd0);
    check("s1_clk_first", 32'(flash_clk), 32'd0);
    step(1);
    check("s1_clk_rise", 32'(flash_clk), 32'd1);
    step(T0 - 1 - cyc);
    check("s1_csb_before_end", 32'(flash_csb), 32'd0);
    check("s1_gpio_before", 32'(gpio), 32'd0);
    step(1);
    check("s1_csb_end", 32'(flash_csb), 32'd1);
    check("s1_clk_end", 32'(flash_clk), 32'd0);
    check("s1_gpio_first", 32'(gpio), 32'd1);
    wait_done(1000);
    check("s1_done_cycle", 32'(cyc), 32'(T0 + 80));
    check("s1_cmd", mosi[BITS_EXP-1 -: 32], CMD_EXP);
    check("s1_io0_tail", mosi[39:8], 32'd0);
    check("s1_io0_tail2", 32'(mosi[7:0]), 32'd0);
    check("s1_spi_bits", 32'(spi_cnt), 32'(BITS_EXP));
    check("s1_pulses", 32'(pulses), 32'd10);
    check("s1_hi_min", 32'(hi_min), 32'd4);
    check("s1_hi_max", 32'(hi_max), 32'd4);
    check("s1_lo_min", 32'(lo_min), 32'd4);
    check("s1_lo_max", 32'(lo_max), 32'd4);
    check("s1_count", 32'(checkbits_hi), 32'd10);
    check("s1_gpio_end", 32'(gpio), 32'd0);
    step(20);
    check("s1_done_hold", 32'(done), 32'd1);
    check("s1_count_hold", 32'(checkbits_hi), 32'd10);
    check("s1_csb_hold", 32'(flash_csb), 32'd1);

    // Scenario 2: N=0
    checkbits_lo = 8'h3C;
    start(32'h00000004, 3);
    wait_done(1000);
    check("s2_done_cycle", 32'(cyc), 32'(T0));
    check("s2_spi_bits", 32'(spi_cnt), 32'(BITS_EXP));
    check("s2_csb", 32'(flash_csb), 32'd1);
    check("s2_pulses", 32'(pulses), 32'd0);
    check("s2_gpio", 32'(gpio), 32'd0);
    check("s2_count", 32'(checkbits_hi), 32'd0);

    // Scenario 3: N=3, H=0 treated as 1
    start(32'h03000000, 3);
    wait_done(1000);
    check("s3_done_cycle", 32'(cyc), 32'(T0 + 6));
    check("s3_pulses", 32'(pulses), 32'd3);
    check("s3_hi_max", 32'(hi_max), 32'd1);
    check("s3_lo_max", 32'(lo_max), 32'd1);
    check("s3_count", 32'(checkbits_hi), 32'd3);

    // Scenario 4: reset during the 2nd blink, then full rerun
    start(32'h0A000004, 3);
    step(T0 + 10 - cyc);
    check("s4_gpio_2nd", 32'(gpio), 32'd1);
    check("s4_count_2nd", 32'(checkbits_hi), 32'd1);
    resetb = 1'b0;
    #1;
    check("s4_async_gpio", 32'(gpio), 32'd0);
    check("s4_async_csb", 32'(flash_csb), 32'd1);
    check("s4_async_count", 32'(checkbits_hi), 32'd0);
    check("s4_async_clk", 32'(flash_clk), 32'd0);
    start(32'h0A000004, 5);
    step(1);
    check("s4_refetch_csb", 32'(flash_csb), 32'd0);
    wait_done(1000);
    check("s4_done_cycle", 32'(cyc), 32'(T0 + 80));
    check("s4_spi_bits", 32'(spi_cnt), 32'(BITS_EXP));
    check("s4_pulses", 32'(pulses), 32'd10);
    check("s4_count", 32'(checkbits_hi), 32'd10);

    // Scenario 5: N=2, H=256
    start(32'h02000100, 3);
    step(T0 + 255 - cyc);
    check("s5_hi_last", 32'(gpio), 32'd1);
    step(1);
    check("s5_lo_first", 32'(gpio), 32'd0);
    step(T0 + 511 - cyc);
    check("s5_count0", 32'(checkbits_hi), 32'd0);
    step(1);
    check("s5_count1", 32'(checkbits_hi), 32'd1);
    check("s5_gpio_2nd", 32'(gpio), 32'd1);
    step(T0 + 1023 - cyc);
    check("s5_count1_hold", 32'(checkbits_hi), 32'd1);
    check("s5_done_not_yet", 32'(done), 32'd0);
    step(1);
    check("s5_count2", 32'(checkbits_hi), 32'd2);
    check("s5_done", 32'(done), 32'd1);
    check("s5_hi_min", 32'(hi_min), 32'd256);
    check("s5_hi_max", 32'(hi_max), 32'd256);
    check("s5_lo", 32'(lo_max), 32'd256);

    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mgmt_gpio_flash_blinker.md
Name: mgmt_gpio_flash_blinker

Overview:
Boot-time management-GPIO sequencer. After reset it fetches a 4-byte blink descriptor from an external SPI flash, then toggles the management `gpio` pad a programmed number of times at a programmed half-period. It exposes progress on an 8-bit check bus. It sits between the chip reset/clock pads, the flash pins and the mgmt GPIO pad, and is a minimal stand-in for the SoC boot path used in GPIO bring-up.

Parameters:
FLASH_BASE, 24'h000000, byte address of the blink descriptor in flash.
MAX_COUNT, 8'hFF, saturation value of the completed-blink counter.

Ports:
clock  input  1  system clock; all logic on rising edge.
resetb  input  1  asynchronous active-low reset.
flash_csb  output  1  flash chip select, active low.
flash_clk  output  1  SPI clock, mode 0.
flash_io0  output  1  SPI MOSI.
flash_io1  input  1  SPI MISO.
gpio  output  1  management GPIO pad output.
checkbits_lo  input  8  host-driven check value; registered only.
checkbits_hi  output  8  completed-blink count.
done  output  1  high once the sequence has finished.

Behaviour:
- One clock, `clock`. Reset is asynchronous and active-low on `resetb`.
- Reset values: flash_csb=1, flash_clk=0, flash_io0=0, gpio=0, checkbits_hi=0, done=0, state=IDLE.
- States: IDLE -> CMD -> DATA -> BLINK_HI <-> BLINK_LO -> DONE.
- IDLE lasts exactly 1 cycle after reset release. On leaving IDLE:
  - flash_csb goes to 0.
  - The 32-bit shift word {8'h03, FLASH_BASE} is loaded.
- SPI timing:
  - flash_clk toggles every clock cycle while flash_csb=0, so SPI period = 2 clocks.
  - flash_io0 changes only on the clock edge that drives flash_clk low.
  - MSB first.
- CMD:
  - 32 SPI bits (64 clocks), then go to DATA.
- DATA:
  - 32 SPI bits.
  - flash_io1 is sampled on the clock edge that drives flash_clk 0->1.
  - Byte0 = N (blink count). Bytes1..3 = H (24-bit half-period, big-endian).
  - After the last bit: flash_clk=0 and flash_csb=1 on the next cycle.
- Descriptor handling:
  - H=0 is treated as H=1.
  - N=0 goes straight to DONE; gpio never rises.
- BLINK_HI: gpio=1 for exactly H clocks.
- BLINK_LO:
  - gpio=0 for exactly H clocks.
  - At its end, checkbits_hi increments, saturating at MAX_COUNT.
  - If checkbits_hi now equals N, go to DONE; otherwise go to BLINK_HI.
- DONE: gpio=0, done=1, flash idle (csb=1, clk=0). The state is held until reset.
- checkbits_lo is registered internally but has no effect on sequencing. It is reserved for host observability.
- Reset asserted mid-operation: all outputs return to reset values immediately. The sequence restarts from IDLE after release, including a fresh flash fetch.
- Counters are 24-bit; no wrap is possible for H ≤ 2^24-1.

Optional Feature:
FLASH_FAST_READ_EN
- Defined:
  - The command byte is 8'h0B.
  - The address is followed by 8 dummy SPI clocks (io0=0, io1 ignored) before DATA.
  - Fetch is 16 clocks longer.
- Undefined: the command byte is 8'h03 with no dummy cycles.
- All other behaviour is identical.

Test Plan:
- Flash bytes 0A 00 00 04 at FLASH_BASE=0:
  - First 32 bits on io0 are 0x03000000.
  - gpio produces 10 pulses, each 4 high / 4 low clocks.
  - Final checkbits_hi=8'd10, done=1, gpio=0.
- Flash bytes 00 00 00 04:
  - flash_csb returns to 1 after 64 SPI bits.
  - gpio stays 0; done=1; checkbits_hi=0.
- Flash bytes 03 00 00 00:
  - H treated as 1: 3 pulses of 1 high / 1 low clock.
  - checkbits_hi=3.
- Reset pulse (resetb=0 for 5 clocks) during the 2nd blink:
  - gpio=0, flash_csb=1, checkbits_hi=0 asynchronously.
  - After release, the fetch repeats and 10 blinks complete (bytes 0A 00 00 04).
- Bytes 02 00 01 00:
  - Each high phase lasts exactly 256 clocks.
  - checkbits_hi steps 0->1->2 at the end of each low phase.
- With FLASH_FAST_READ_EN defined:
  - io0 shows 0x0B000000 then 8 zero bits.
  - Blink behaviour matches scenario 1.
